// File: rtl/aurora_flush_pkg.sv
// Shared definitions for the Aurora TX filler generator.
//   state_t      : FSM encoding (IDLE=0, CLR=1, POP=2, DONE=3)
//   *_WORD_DEF   : default 128-bit beat patterns
//   rep_pattern  : replicates a 128-bit pattern to PAT_MAX_WD bits; callers
//                  keep the low DATA_WD bits
package aurora_flush_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CLR  = 2'd1,
    ST_POP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [127:0] CLR_WORD_DEF = 128'hAABBCCDD_AA55FF00_55AA0001_00000001;
  localparam logic [127:0] PAD_WORD_DEF = 128'h5A5ADEAD_0000FFFF_5A5ADEAD_0000FFFF;

  localparam int PAT_MAX_WD = 1024;

  function automatic logic [PAT_MAX_WD-1:0] rep_pattern(input logic [127:0] pat);
    return {(PAT_MAX_WD/128){pat}};
  endfunction

endpackage

// File: rtl/aurora_flush_gen_if.sv
// AXI-Stream link from the filler generator to the Aurora TX arbiter.
//   master : tdata, tkeep, tvalid, tlast out; tready in
//   slave  : mirror image
interface aurora_flush_gen_if #(
  parameter int DATA_WD = 128
);
  logic [DATA_WD-1:0]   tdata;
  logic [DATA_WD/8-1:0] tkeep;
  logic                 tvalid;
  logic                 tready;
  logic                 tlast;

  modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/aurora_flush_sync.sv
// N-bit two-flop synchroniser with rising-edge detect.
//   i_async : asynchronous levels
//   o_lvl   : synchronised level (second flop)
//   o_rise  : one-cycle pulse, first flop high while second still low
module aurora_flush_sync #(
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] i_async,
  output logic [N-1:0] o_lvl,
  output logic [N-1:0] o_rise
);
  logic [N-1:0] r_d1;
  logic [N-1:0] r_d2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d1 <= '0;
      r_d2 <= '0;
    end else begin
      r_d1 <= i_async;
      r_d2 <= r_d1;
    end
  end

  assign o_lvl  = r_d2;
  assign o_rise = r_d1 & ~r_d2;
endmodule

// File: rtl/cmip_app_cnt.sv
// Free-running event counter, wraps at 2^WD.
//   i_inc : count one event this cycle
//   o_cnt : current count
module cmip_app_cnt #(
  parameter int WD = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_inc,
  output logic [WD-1:0] o_cnt
);
  logic [WD-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_cnt <= '0;
    else if (i_inc) r_cnt <= r_cnt + WD'(1);
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/aurora_flush_gen.sv
// Aurora TX filler generator: clear bursts on config reset, pad/flush
// streams on completion triggers, packet-granular abort, event statistics.
//   clk, rst_n          : clock, async active-low reset
//   i_cfg_rst           : async; rising edge requests a clear burst
//   i_trig_en           : async; gates triggers
//   i_trig              : async; rising edge of any bit requests a flush
//   i_abort             : async; rising edge stops the flush at packet end
//   i_cfg_pop_beats     : flush length in beats (0 treated as 1)
//   i_cfg_pkt_beats     : beats per flush packet (0 = single packet)
//   o_busy/o_pop_active : FSM status
//   o_last_trig_src     : trigger edge vector of the latest flush
//   m_axis              : AXI-Stream master
//   o_*_cnt             : clear/full/abort/drop event counters
//
// state | meaning
// IDLE  | waiting for cfg_rst or enabled trigger edge
// CLR   | emitting CLR_BEATS single-beat clear words
// POP   | emitting pad beats framed into packets
// DONE  | one cycle; bump the matching statistics counter
module aurora_flush_gen
  import aurora_flush_pkg::*;
#(
  parameter int           DATA_WD   = 128,
  parameter int           TRIG_NUM  = 3,
  parameter int           CNT_WD    = 24,
  parameter int           PKT_WD    = 16,
  parameter int           CLR_BEATS = 20,
  parameter logic [127:0] CLR_WORD  = CLR_WORD_DEF,
  parameter logic [127:0] PAD_WORD  = PAD_WORD_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_cfg_rst,
  input  logic                 i_trig_en,
  input  logic [TRIG_NUM-1:0]  i_trig,
  input  logic                 i_abort,
  input  logic [CNT_WD-1:0]    i_cfg_pop_beats,
  input  logic [PKT_WD-1:0]    i_cfg_pkt_beats,
  output logic                 o_busy,
  output logic                 o_pop_active,
  output logic [TRIG_NUM-1:0]  o_last_trig_src,
  aurora_flush_gen_if.master   m_axis,
  output logic [31:0]          o_clr_done_cnt,
  output logic [31:0]          o_pop_done_cnt,
  output logic [31:0]          o_abort_cnt,
  output logic [31:0]          o_drop_cnt
);

  localparam logic [PAT_MAX_WD-1:0] CLR_REP  = rep_pattern(CLR_WORD);
  localparam logic [PAT_MAX_WD-1:0] PAD_REP  = rep_pattern(PAD_WORD);
  localparam logic [DATA_WD-1:0]    CLR_BEAT = CLR_REP[DATA_WD-1:0];
  localparam logic [DATA_WD-1:0]    PAD_BEAT = PAD_REP[DATA_WD-1:0];
  localparam logic [CNT_WD-1:0]     CNT_ONE  = CNT_WD'(1);
  localparam logic [PKT_WD-1:0]     PKT_ONE  = PKT_WD'(1);
  localparam logic [CNT_WD-1:0]     CLR_LAST = CNT_WD'(CLR_BEATS - 1);
  localparam int                    SYNC_N   = TRIG_NUM + 3;

  // sync bus layout: {abort, trig_en, cfg_rst, trig[]}
  logic [SYNC_N-1:0]   w_async;
  logic [SYNC_N-1:0]   w_lvl;
  logic [SYNC_N-1:0]   w_rise;
  logic [TRIG_NUM-1:0] w_trig_edge;
  logic                w_cfg_edge;
  logic                w_trig_en;
  logic                w_abort_edge;
  logic                w_trig_req;
  logic                w_unused;

  assign w_async = {i_abort, i_trig_en, i_cfg_rst, i_trig};

  aurora_flush_sync #(.N(SYNC_N)) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (w_async),
    .o_lvl   (w_lvl),
    .o_rise  (w_rise)
  );

  assign w_trig_edge  = w_rise[TRIG_NUM-1:0];
  assign w_cfg_edge   = w_rise[TRIG_NUM];
  assign w_trig_en    = w_lvl[TRIG_NUM+1];
  assign w_abort_edge = w_rise[TRIG_NUM+2];
  assign w_trig_req   = (|w_trig_edge) & w_trig_en;
  assign w_unused     = ^{w_lvl[TRIG_NUM:0], w_rise[TRIG_NUM+1], w_lvl[TRIG_NUM+2]};

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_WD-1:0]   r_beat_cnt;
  logic [PKT_WD-1:0]   r_pkt_cnt;
  logic [CNT_WD-1:0]   r_len;
  logic [PKT_WD-1:0]   r_pkt;
  logic [TRIG_NUM-1:0] r_last_src;
  logic                r_abort_pend;
  logic                r_done_clr;
  logic                r_done_abort;
  logic                r_tvalid;
  logic                r_tlast;
  logic [DATA_WD-1:0]  r_tdata;
  logic                w_done_abort;

  logic                w_hs;
  logic                w_clr_last;
  logic                w_pop_last;
  logic [CNT_WD-1:0]   w_beat_nxt;
  logic [PKT_WD-1:0]   w_pkt_cnt_nxt;
  logic                w_tlast_cur;
  logic                w_tlast_nxt;

  assign w_hs       = r_tvalid & m_axis.tready;
  assign w_clr_last = (r_beat_cnt == CLR_LAST);
  assign w_pop_last = (r_beat_cnt == r_len - CNT_ONE);

  // tlast for the beat at the current counters, and for the beat after a handshake
  assign w_tlast_cur   = ((r_pkt != '0) && (r_pkt_cnt == r_pkt - PKT_ONE)) || w_pop_last;
  assign w_beat_nxt    = r_beat_cnt + CNT_ONE;
  assign w_pkt_cnt_nxt = r_tlast ? '0 : r_pkt_cnt + PKT_ONE;
  assign w_tlast_nxt   = ((r_pkt != '0) && (w_pkt_cnt_nxt == r_pkt - PKT_ONE)) ||
                         (w_beat_nxt == r_len - CNT_ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_done_abort = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cfg_edge)      w_state_nxt = ST_CLR;
        else if (w_trig_req) w_state_nxt = ST_POP;
      end
      ST_CLR: begin
        if (w_hs && w_clr_last) w_state_nxt = ST_DONE;
      end
      ST_POP: begin
        // final beat wins over a pending abort: counts as a full flush
        if (w_hs && w_pop_last) begin
          w_state_nxt = ST_DONE;
        end else if (w_hs && r_tlast && r_abort_pend) begin
          w_state_nxt  = ST_DONE;
          w_done_abort = 1'b1;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_cnt   <= '0;
      r_pkt_cnt    <= '0;
      r_len        <= '0;
      r_pkt        <= '0;
      r_last_src   <= '0;
      r_abort_pend <= 1'b0;
      r_done_clr   <= 1'b0;
      r_done_abort <= 1'b0;
      r_tvalid     <= 1'b0;
      r_tlast      <= 1'b0;
      r_tdata      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_beat_cnt <= '0;
          r_pkt_cnt  <= '0;
          r_tvalid   <= 1'b0;
          r_tlast    <= 1'b0;
          if (!w_cfg_edge && w_trig_req) begin
            r_len      <= (i_cfg_pop_beats == '0) ? CNT_ONE : i_cfg_pop_beats;
            r_pkt      <= i_cfg_pkt_beats;
            r_last_src <= w_trig_edge;
          end
        end
        ST_CLR: begin
          if (!r_tvalid) begin
            r_tvalid <= 1'b1;
            r_tlast  <= 1'b1;
            r_tdata  <= CLR_BEAT;
          end else if (w_hs) begin
            r_beat_cnt <= w_beat_nxt;
            if (w_clr_last) r_tvalid <= 1'b0;
          end
        end
        ST_POP: begin
          if (w_abort_edge) r_abort_pend <= 1'b1;
          if (!r_tvalid) begin
            r_tvalid <= 1'b1;
            r_tlast  <= w_tlast_cur;
            r_tdata  <= PAD_BEAT;
          end else if (w_hs) begin
            if (w_state_nxt == ST_DONE) begin
              r_tvalid <= 1'b0;
            end else begin
              r_beat_cnt <= w_beat_nxt;
              r_pkt_cnt  <= w_pkt_cnt_nxt;
              r_tlast    <= w_tlast_nxt;
            end
          end
        end
        ST_DONE: begin
          r_tvalid     <= 1'b0;
          r_abort_pend <= 1'b0;
        end
        default: r_tvalid <= 1'b0;
      endcase

      if (w_state_nxt == ST_DONE && r_state != ST_DONE) begin
        r_done_clr   <= (r_state == ST_CLR);
        r_done_abort <= w_done_abort;
      end
    end
  end

  logic w_inc_clr;
  logic w_inc_pop;
  logic w_inc_abort;
  logic w_inc_drop;

  assign w_inc_clr   = (r_state == ST_DONE) &  r_done_clr;
  assign w_inc_pop   = (r_state == ST_DONE) & ~r_done_clr & ~r_done_abort;
  assign w_inc_abort = (r_state == ST_DONE) & ~r_done_clr &  r_done_abort;
  // in IDLE only a simultaneous cfg_rst + trigger loses the trigger
  assign w_inc_drop  = (r_state != ST_IDLE) ? (w_cfg_edge | w_trig_req)
                                            : (w_cfg_edge & w_trig_req);

  cmip_app_cnt #(.WD(32)) u_cnt_clr   (.clk(clk), .rst_n(rst_n), .i_inc(w_inc_clr),   .o_cnt(o_clr_done_cnt));
  cmip_app_cnt #(.WD(32)) u_cnt_pop   (.clk(clk), .rst_n(rst_n), .i_inc(w_inc_pop),   .o_cnt(o_pop_done_cnt));
  cmip_app_cnt #(.WD(32)) u_cnt_abort (.clk(clk), .rst_n(rst_n), .i_inc(w_inc_abort), .o_cnt(o_abort_cnt));
  cmip_app_cnt #(.WD(32)) u_cnt_drop  (.clk(clk), .rst_n(rst_n), .i_inc(w_inc_drop),  .o_cnt(o_drop_cnt));

  assign o_busy          = (r_state != ST_IDLE);
  assign o_pop_active    = (r_state == ST_POP);
  assign o_last_trig_src = r_last_src;

  assign m_axis.tdata  = r_tdata;
  assign m_axis.tkeep  = '1;
  assign m_axis.tvalid = r_tvalid;
  assign m_axis.tlast  = r_tlast;

endmodule

// File: tb/tb_aurora_flush_gen.sv
module tb_aurora_flush_gen;

  localparam logic [127:0] CLR_W = 128'hAABBCCDD_AA55FF00_55AA0001_00000001;
  localparam logic [127:0] PAD_W = 128'h5A5ADEAD_0000FFFF_5A5ADEAD_0000FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_rst = 1'b0;
  logic        trig_en = 1'b0;
  logic [2:0]  trig = 3'b000;
  logic        abort = 1'b0;
  logic [23:0] pop_beats = '0;
  logic [15:0] pkt_beats = '0;
  logic        busy, pop_active;
  logic [2:0]  last_src;
  logic [31:0] clr_cnt, pop_cnt, abort_cnt, drop_cnt;
  int          rdy_pct = 100;

  aurora_flush_gen_if #(.DATA_WD(128)) axis ();

  aurora_flush_gen dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_cfg_rst       (cfg_rst),
    .i_trig_en       (trig_en),
    .i_trig          (trig),
    .i_abort         (abort),
    .i_cfg_pop_beats (pop_beats),
    .i_cfg_pkt_beats (pkt_beats),
    .o_busy          (busy),
    .o_pop_active    (pop_active),
    .o_last_trig_src (last_src),
    .m_axis          (axis),
    .o_clr_done_cnt  (clr_cnt),
    .o_pop_done_cnt  (pop_cnt),
    .o_abort_cnt     (abort_cnt),
    .o_drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;

  initial axis.tready = 1'b0;
  always @(posedge clk) begin
    #1 axis.tready = ($urandom_range(0, 99) < rdy_pct);
  end

  typedef struct { logic [127:0] data; logic last; } beat_t;
  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    seen = 0;
  int    exp_clr = 0, exp_pop = 0, exp_abort = 0, exp_drop = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model: stream content from the rules, not from RTL structure
  task automatic push_clr();
    for (int i = 0; i < 20; i++) exp_q.push_back('{CLR_W, 1'b1});
  endtask

  task automatic push_flush(input int len, input int pkt, input int abort_at);
    int l;
    logic lst;
    l = (len == 0) ? 1 : len;
    for (int i = 0; i < l; i++) begin
      lst = ((pkt != 0) && ((i % pkt) == pkt - 1)) || (i == l - 1);
      exp_q.push_back('{PAD_W, lst});
      if (lst && i >= abort_at) break;
    end
  endtask

  // monitor / scoreboard
  logic         prev_stall = 1'b0;
  logic [127:0] prev_data;
  logic         prev_last;
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!(axis.tvalid === 1'b1 && axis.tdata === prev_data && axis.tlast === prev_last)) begin
          errors++;
          $display("FAIL stall_hold: got v=%0b d=%0h l=%0b expected v=1 d=%0h l=%0b",
                   axis.tvalid, axis.tdata, axis.tlast, prev_data, prev_last);
        end
      end
      if (axis.tvalid && axis.tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected: got d=%0h l=%0b expected no beat", axis.tdata, axis.tlast);
        end else begin
          e = exp_q.pop_front();
          if (axis.tdata !== e.data || axis.tlast !== e.last) begin
            errors++;
            $display("FAIL beat_%0d: got d=%0h l=%0b expected d=%0h l=%0b",
                     seen, axis.tdata, axis.tlast, e.data, e.last);
          end
        end
        seen++;
      end
      prev_stall = axis.tvalid && !axis.tready;
      prev_data  = axis.tdata;
      prev_last  = axis.tlast;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic c, input logic [2:0] t, input logic a);
    cfg_rst = c; trig = t; abort = a;
    tick(3);
    cfg_rst = 1'b0; trig = 3'b000; abort = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 5000) begin
      tick(1);
      n++;
    end
    checks++;
    if (n >= 5000) begin
      errors++;
      $display("FAIL %s_timeout: got busy=%0b pending=%0d expected idle", name, busy, exp_q.size());
      exp_q.delete();
    end
    tick(2);
  endtask

  task automatic wait_beats(input int n, input string name);
    int base, c;
    base = seen;
    c = 0;
    while (seen - base < n && c < 5000) begin
      tick(1);
      c++;
    end
    checks++;
    if (c >= 5000) begin
      errors++;
      $display("FAIL %s_timeout: got %0d beats expected %0d", name, seen - base, n);
    end
  endtask

  task automatic chk_cnts(input string tag);
    chk({tag, "_clr_cnt"},   clr_cnt,   exp_clr);
    chk({tag, "_pop_cnt"},   pop_cnt,   exp_pop);
    chk({tag, "_abort_cnt"}, abort_cnt, exp_abort);
    chk({tag, "_drop_cnt"},  drop_cnt,  exp_drop);
  endtask

  initial begin
    int len, pkt;
    logic [2:0] tv;

    // reset state
    tick(3);
    chk("rst_tvalid", axis.tvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tkeep", axis.tkeep, 16'hFFFF);
    chk("rst_last_src", last_src, 0);
    chk_cnts("rst");
    rst_n = 1'b1;
    tick(2);

    // clear burst with latency check
    rdy_pct = 100;
    push_clr();
    cfg_rst = 1'b1;
    tick(2);
    chk("clr_lat_tvalid_early", axis.tvalid, 0);
    chk("clr_busy", busy, 1);
    tick(1);
    chk("clr_lat_tvalid", axis.tvalid, 1);
    cfg_rst = 1'b0;
    wait_idle("clr");
    exp_clr++;
    chk_cnts("clr");

    // flush 10/4 from trig[1], random backpressure
    trig_en = 1'b1;
    pop_beats = 24'd10;
    pkt_beats = 16'd4;
    rdy_pct = 50;
    tick(3);
    push_flush(10, 4, 32'h7fffffff);
    pulse(1'b0, 3'b010, 1'b0);
    chk("pop_active", pop_active, 1);
    wait_idle("pop10");
    exp_pop++;
    chk_cnts("pop10");
    chk("pop10_last_src", last_src, 3'b010);

    // trigger while disabled
    trig_en = 1'b0;
    tick(3);
    pulse(1'b0, 3'b001, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("dis_busy", busy, 0);
      tick(1);
    end
    chk_cnts("dis");
    trig_en = 1'b1;
    tick(3);

    // abort in IDLE is ignored
    pulse(1'b0, 3'b000, 1'b1);
    tick(3);
    chk("idle_abort_busy", busy, 0);
    chk_cnts("idle_abort");

    // abort at beat 250 of a 1000/100 flush
    rdy_pct = 100;
    pop_beats = 24'd1000;
    pkt_beats = 16'd100;
    tick(1);
    push_flush(1000, 100, 250);
    pulse(1'b0, 3'b100, 1'b0);
    wait_beats(247, "abort_wait");
    pulse(1'b0, 3'b000, 1'b1);
    wait_idle("abort");
    exp_abort++;
    chk_cnts("abort");

    // drops: trig during CLR, then simultaneous cfg_rst + trig in IDLE
    push_clr();
    pulse(1'b1, 3'b000, 1'b0);
    tick(2);
    pulse(1'b0, 3'b001, 1'b0);
    exp_drop++;
    wait_idle("drop1");
    exp_clr++;
    push_clr();
    pulse(1'b1, 3'b100, 1'b0);
    exp_drop++;
    chk("drop2_pop_active", pop_active, 0);
    wait_idle("drop2");
    exp_clr++;
    chk_cnts("drop");

    // random flushes, including zero length and zero packet size
    rdy_pct = 60;
    for (int k = 0; k < 6; k++) begin
      len = (k == 0) ? 0 : $urandom_range(1, 40);
      pkt = $urandom_range(0, 7);
      tv  = 3'($urandom_range(1, 7));
      pop_beats = 24'(len);
      pkt_beats = 16'(pkt);
      tick(1);
      push_flush(len, pkt, 32'h7fffffff);
      pulse(1'b0, tv, 1'b0);
      wait_idle("rnd");
      exp_pop++;
      chk("rnd_last_src", last_src, tv);
    end
    chk_cnts("rnd");

    // reset mid-flush at beat 5
    rdy_pct = 100;
    pop_beats = 24'd20;
    pkt_beats = 16'd0;
    tick(1);
    push_flush(20, 0, 32'h7fffffff);
    pulse(1'b0, 3'b001, 1'b0);
    wait_beats(5, "rst_wait");
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_tvalid", axis.tvalid, 0);
    chk("midrst_busy", busy, 0);
    exp_clr = 0; exp_pop = 0; exp_abort = 0; exp_drop = 0;
    chk_cnts("midrst");
    tick(2);
    rst_n = 1'b1;
    tick(3);
    pop_beats = 24'd7;
    pkt_beats = 16'd3;
    push_flush(7, 3, 32'h7fffffff);
    pulse(1'b0, 3'b100, 1'b0);
    wait_idle("post_rst");
    exp_pop++;
    chk_cnts("post_rst");
    chk("post_rst_last_src", last_src, 3'b100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
